addsub_bist: RTL and testbench
==============================

// Module: addsub_bist
// PURPOSE
//   Self-checking sequencer for the 4-bit adder_subtractor. It drives select/a/b
//   and reads r/cout/ovf back on the same port set the bench uses. It sweeps every
//   {select,a,b} combination and checks each response against an internal
//   reference model. It counts mismatches and latches the first failing vector.
//   Sits beside the DUT in place of the stimulus-only bench; usable on silicon.
// PARAMETERS
//   WIDTH  4  operand width; the vector space is 2^(2*WIDTH+1)
//   SETTLE 2  cycles between driving a vector and sampling the DUT (>=1)
//   ERR_W  8  width of the mismatch counter (saturating)
// PORTS
//   clk            in   1          clock, rising edge
//   rst_n          in   1          asynchronous active-low reset
//   start          in   1          pulse/level; begins a sweep when idle or done
//   select         out  1          0=add, 1=subtract; driven to DUT
//   a              out  WIDTH      operand A to DUT
//   b              out  WIDTH      operand B to DUT
//   r              in   WIDTH      DUT result
//   cout           in   1          DUT carry out
//   ovf            in   1          DUT signed overflow
//   busy           out  1          sweep in progress
//   done           out  1          sweep complete; holds until next start or reset
//   pass           out  1          valid while done: 1 if err_count==0
//   err_count      out  ERR_W      mismatch count; saturates at all-ones
//   first_fail     out  2*WIDTH+1  {select,a,b} of first mismatch; 0 if none
// BEHAVIOUR
//   Reset (async, rst_n low): state IDLE; every output = 0. Sweep is abandoned.
//   Vector index vec[2*WIDTH:0]: select=vec[2W], a=vec[2W-1:W], b=vec[W-1:0].
//   Sweep order is 0 .. 2^(2W+1)-1 (all adds, then all subtracts).
//   All outputs are registered; no combinational path from r/cout/ovf to outputs.
//   FSM IDLE/WAIT/CHECK/DONE:
//    IDLE or DONE, start=1: drive vec 0, clear err_count/first_fail/done/pass.
//      Set busy=1. Go to WAIT with settle counter = SETTLE-1.
//    WAIT: decrement the counter; at 0, go to CHECK.
//    CHECK: sample r/cout/ovf and compare with the model.
//      Mismatch: err_count+1 (saturating). If this is the first error, load
//      first_fail = vec.
//      If vec is not last: vec+1 on outputs, go to WAIT.
//      If vec is last: busy=0, done=1, pass=(no error seen), go to DONE.
//      Outputs hold the last vector.
//   Per vector: SETTLE+1 cycles.
//   done rises 2^(2W+1)*(SETTLE+1) cycles after the start edge (1536 at defaults).
//   start while busy: ignored. start held high in DONE: a new sweep starts.
//   Model (all W-bit, modulo 2^W):
//    add: {c,s}=a+b.   sub: {c,s}=a+~b+1. So cout=1 means no borrow (a>=b unsigned).
//    ovf add = (a[W-1]==b[W-1]) && (s[W-1]!=a[W-1]).
//    ovf sub = (a[W-1]!=b[W-1]) && (s[W-1]!=a[W-1]).
//    Any of r, cout, ovf differing from the model = one mismatch for that vector.
//   Saturation: err_count stops at 2^ERR_W-1. first_fail is unaffected.
//   Any X on a sampled input counts as a mismatch (=== compare in model).
// TESTING
//   1 Golden DUT, SETTLE=2, start pulse -> busy 1536 cycles, done=1, pass=1,
//     err_count=0, first_fail=0.
//   2 r[0] stuck-at-0 -> err_count=255 (sat.; 256 raw), first_fail=9'h001, pass=0.
//   3 cout stuck-at-0 -> 256 raw mismatches, err_count=255,
//     first_fail=9'h01F (add 1+15).
//   4 ovf stuck-at-0, ERR_W=10 -> err_count = the bench-computed count of
//     overflowing vectors. first_fail = the first add vector with ovf=1
//     (a=1,b=7 -> 9'h017).
//   5 rst_n low at cycle 700 of a sweep -> all outputs 0 immediately. A new start
//     gives a full sweep matching scenario 1.
//   6 start re-pulsed at cycle 100 mid-sweep -> ignored; done still at cycle 1536.
//     Then start in DONE -> counters cleared and the sweep reruns.

Source files
------------

// File: rtl/addsub_bist.sv
// Built-in self test for the adder_subtractor: sweeps every {select,a,b}, checks r/cout/ovf.
// Each vector takes SETTLE+1 cycles. start is ignored while busy. No backpressure.
module addsub_bist #(
   parameter int WIDTH  = 4,
   parameter int SETTLE = 2,
   parameter int ERR_W  = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   output logic               select,
   output logic [WIDTH-1:0]   a,
   output logic [WIDTH-1:0]   b,
   input  logic [WIDTH-1:0]   r,
   input  logic               cout,
   input  logic               ovf,
   output logic               busy,
   output logic               done,
   output logic               pass,
   output logic [ERR_W-1:0]   err_count,
   output logic [2*WIDTH:0]   first_fail
);
   localparam int VW = 2*WIDTH + 1;
   localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_CHECK, S_DONE} state_t;

   state_t            state_q;
   logic [VW-1:0]     vec_q;
   logic [CW-1:0]     cnt_q;
   logic [ERR_W-1:0]  err_q;
   logic [ERR_W-1:0]  err_d;
   logic [VW-1:0]     ff_q;
   logic              busy_q;
   logic              done_q;
   logic              pass_q;

   logic              sel_w;
   logic [WIDTH-1:0]  a_w;
   logic [WIDTH-1:0]  b_w;
   logic [WIDTH-1:0]  b_eff;
   logic [WIDTH:0]    sum_w;
   logic              exp_ovf;
   logic              mismatch;

   assign sel_w = vec_q[2*WIDTH];
   assign a_w   = vec_q[2*WIDTH-1:WIDTH];
   assign b_w   = vec_q[WIDTH-1:0];

   // Reference: subtract is a + ~b + 1, so cout means "no borrow".
   always_comb begin
      b_eff    = sel_w ? ~b_w : b_w;
      sum_w    = {1'b0, a_w} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sel_w};
      exp_ovf  = (a_w[WIDTH-1] == b_eff[WIDTH-1]) && (sum_w[WIDTH-1] != a_w[WIDTH-1]);
      mismatch = (r !== sum_w[WIDTH-1:0]) || (cout !== sum_w[WIDTH]) || (ovf !== exp_ovf);
      err_d    = (&err_q) ? err_q : err_q + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         vec_q   <= '0;
         cnt_q   <= '0;
         err_q   <= '0;
         ff_q    <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE, S_DONE: begin
               if (start) begin
                  vec_q   <= '0;
                  err_q   <= '0;
                  ff_q    <= '0;
                  done_q  <= 1'b0;
                  pass_q  <= 1'b0;
                  busy_q  <= 1'b1;
                  cnt_q   <= CW'(SETTLE - 1);
                  state_q <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (cnt_q == '0) state_q <= S_CHECK;
               else             cnt_q   <= cnt_q - 1'b1;
            end
            S_CHECK: begin
               if (mismatch) begin
                  err_q <= err_d;
                  if (err_q == '0) ff_q <= vec_q;
               end
               if (&vec_q) begin
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  pass_q  <= (err_q == '0) && !mismatch;
                  state_q <= S_DONE;
               end else begin
                  vec_q   <= vec_q + 1'b1;
                  cnt_q   <= CW'(SETTLE - 1);
                  state_q <= S_WAIT;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign select     = sel_w;
   assign a          = a_w;
   assign b          = b_w;
   assign busy       = busy_q;
   assign done       = done_q;
   assign pass       = pass_q;
   assign err_count  = err_q;
   assign first_fail = ff_q;
endmodule

// File: tb/tb_addsub_bist.sv
// Bench for addsub_bist: behavioural adder with injectable stuck-at faults, cycle-level output model.
module tb_addsub_bist;
   localparam int NV    = 512;
   localparam int PER   = 3;
   localparam int TOTAL = NV * PER;

   logic clk = 1'b0;
   logic rst_n;
   logic start;
   always #5 clk = ~clk;

   logic       sel8, cout8, ovf8, busy8, done8, pass8;
   logic [3:0] a8, b8, r8;
   logic [7:0] err8;
   logic [8:0] ff8;
   logic       sel10, cout10, ovf10, busy10, done10, pass10;
   logic [3:0] a10, b10, r10;
   logic [9:0] err10;
   logic [8:0] ff10;

   int fault;
   int n_cmp = 0;
   int n_fail = 0;
   bit cmp_en = 0;

   // Device under BIST: 0 golden, 1 r[0] sa0, 2 cout sa0, 3 ovf sa0.
   function automatic logic [5:0] adder(input int f, input logic s, input logic [3:0] x, input logic [3:0] y);
      int sx, sy, res;
      logic [3:0] rr;
      logic c, o;
      sx = x[3] ? int'(x) - 16 : int'(x);
      sy = y[3] ? int'(y) - 16 : int'(y);
      if (s) begin
         res = sx - sy;
         c   = (x >= y);
         rr  = x - y;
      end else begin
         res = sx + sy;
         c   = (int'(x) + int'(y)) > 15;
         rr  = x + y;
      end
      o = (res > 7) || (res < -8);
      if (f == 1) rr[0] = 1'b0;
      if (f == 2) c = 1'b0;
      if (f == 3) o = 1'b0;
      return {o, c, rr};
   endfunction

   assign {ovf8, cout8, r8}    = adder(fault, sel8, a8, b8);
   assign {ovf10, cout10, r10} = adder(fault, sel10, a10, b10);

   addsub_bist #(.WIDTH(4), .SETTLE(2), .ERR_W(8)) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .select(sel8), .a(a8), .b(b8), .r(r8), .cout(cout8), .ovf(ovf8),
      .busy(busy8), .done(done8), .pass(pass8), .err_count(err8), .first_fail(ff8));

   addsub_bist #(.WIDTH(4), .SETTLE(2), .ERR_W(10)) u_dut10 (
      .clk(clk), .rst_n(rst_n), .start(start),
      .select(sel10), .a(a10), .b(b10), .r(r10), .cout(cout10), .ovf(ovf10),
      .busy(busy10), .done(done10), .pass(pass10), .err_count(err10), .first_fail(ff10));

   logic [31:0] obs8, obs10;
   assign obs8  = {1'b0, sel8, a8, b8, busy8, done8, pass8, 2'b00, err8, ff8};
   assign obs10 = {1'b0, sel10, a10, b10, busy10, done10, pass10, err10, ff10};

   // Per-sweep fault profile: cum[i] = faulty vectors among 0..i-1.
   int cum[NV+1];
   int cum_next[NV+1];
   int first_bad, first_next;

   task automatic set_fault(input int f);
      logic [8:0] vv;
      fault = f;
      cum_next[0] = 0;
      first_next = -1;
      for (int v = 0; v < NV; v++) begin
         vv = 9'(v);
         if (adder(f, vv[8], vv[7:4], vv[3:0]) != adder(0, vv[8], vv[7:4], vv[3:0])) begin
            cum_next[v+1] = cum_next[v] + 1;
            if (first_next < 0) first_next = v;
         end else begin
            cum_next[v+1] = cum_next[v];
         end
      end
   endtask

   bit active = 0;
   int k = 0;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         active = 0;
         k = 0;
      end else if (start && (!active || k >= TOTAL)) begin
         active = 1;
         k = 0;
         cum = cum_next;
         first_bad = first_next;
      end else if (active && k < TOTAL) begin
         k++;
      end
   end

   function automatic logic [31:0] expect_obs(input int errmax);
      int chk, vec, raw, ff;
      if (!active) return '0;
      chk = k / PER;
      if (chk > NV) chk = NV;
      vec = (chk > NV - 1) ? NV - 1 : chk;
      raw = cum[chk];
      ff  = (first_bad >= 0 && first_bad < chk) ? first_bad : 0;
      return {1'b0, 9'(vec), 1'(k < TOTAL), 1'(k >= TOTAL), 1'(k >= TOTAL && cum[NV] == 0),
              10'((raw > errmax) ? errmax : raw), 9'(ff)};
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (cmp_en) begin
         check("cycle_w8", obs8, expect_obs(255));
         check("cycle_w10", obs10, expect_obs(1023));
      end
   end

   // Counts edges from the start edge until done, optionally re-pulsing start at edge rp.
   task automatic wait_done(input int cyc0, input int rp, output int cyc);
      cyc = cyc0;
      while (done8 !== 1'b1 && cyc < 2000) begin
         @(posedge clk); #1;
         cyc++;
         if (cyc == rp)     start = 1'b1;
         if (cyc == rp + 1) start = 1'b0;
      end
   endtask

   task automatic pulse_start();
      @(negedge clk); start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
   endtask

   task automatic sweep(input int rp, output int cyc);
      pulse_start();
      wait_done(0, rp, cyc);
   endtask

   task automatic check_golden(input string tag, input int cyc);
      check({tag, "_cycles"}, 32'(cyc), 32'd1536);
      check({tag, "_done"}, 32'(done8), 32'd1);
      check({tag, "_busy"}, 32'(busy8), 32'd0);
      check({tag, "_pass"}, 32'(pass8), 32'd1);
      check({tag, "_err"}, 32'(err8), 32'd0);
      check({tag, "_ff"}, 32'(ff8), 32'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc;
      rst_n = 1'b0;
      start = 1'b0;
      set_fault(0);
      #12;
      check("reset_outs", obs8, 32'h0);
      cmp_en = 1;
      @(negedge clk) rst_n = 1'b1;
      repeat (3) @(negedge clk);

      // Golden sweep
      sweep(-1, cyc);
      check_golden("s1", cyc);

      // r[0] stuck-at-0
      set_fault(1);
      check("s2_model_raw", 32'(cum_next[NV]), 32'd256);
      sweep(-1, cyc);
      check("s2_err8", 32'(err8), 32'd255);
      check("s2_err10", 32'(err10), 32'd256);
      check("s2_ff", 32'(ff8), 32'h001);
      check("s2_pass", 32'(pass8), 32'd0);

      // cout stuck-at-0
      set_fault(2);
      sweep(-1, cyc);
      check("s3_err8", 32'(err8), 32'd255);
      check("s3_err10", 32'(err10), 32'd256);
      check("s3_ff", 32'(ff8), 32'h01F);

      // ovf stuck-at-0
      set_fault(3);
      check("s4_model_raw", 32'(cum_next[NV]), 32'd128);
      sweep(-1, cyc);
      check("s4_err10", 32'(err10), 32'(cum[NV]));
      check("s4_err8", 32'(err8), 32'd128);
      check("s4_ff", 32'(ff10), 32'h017);
      check("s4_pass", 32'(pass10), 32'd0);

      // Reset mid-sweep, then full rerun
      set_fault(0);
      pulse_start();
      repeat (700) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("s5_rst_w8", obs8, 32'h0);
      check("s5_rst_w10", obs10, 32'h0);
      @(negedge clk) rst_n = 1'b1;
      sweep(-1, cyc);
      check_golden("s5", cyc);

      // start re-pulsed mid-sweep is ignored
      set_fault(1);
      sweep(100, cyc);
      check("s6_cycles", 32'(cyc), 32'd1536);
      check("s6_err", 32'(err8), 32'd255);

      // start held two cycles in DONE restarts once and clears counters
      set_fault(0);
      @(negedge clk); start = 1'b1;
      @(posedge clk); #1;
      check("s6_restart_busy", 32'(busy8), 32'd1);
      check("s6_restart_err", 32'(err8), 32'd0);
      check("s6_restart_ff", 32'(ff8), 32'd0);
      check("s6_restart_done", 32'(done8), 32'd0);
      @(posedge clk); #1 start = 1'b0;
      wait_done(1, -1, cyc);
      check_golden("s6b", cyc);

      repeat (4) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
